if_id_skid_register: RTL
========================

Name: if_id_skid_register

Overview:
- Registered IF→ID pipeline boundary for the RISC-V core.
- Consumes the fetch stage's selected PC and instruction, i.e. the output of the PC/instruction select multiplexers.
- Presents them to decode through a valid/ready handshake, with a 2-entry skid buffer so that in_ready is driven from a register.
- Supports a pipeline flush for taken branches and jumps.

Parameters:
- n, 32, PC width in bits.
- IW, 32, instruction width in bits.
- NOP_WORD, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  fetch presents in_pc/in_inst.
- in_ready  output  1  stage can accept; registered.
- in_pc  input  n  fetched PC.
- in_inst  input  IW  fetched instruction.
- flush  input  1  discard all held and incoming entries.
- out_valid  output  1  out_pc/out_inst valid for decode.
- out_ready  input  1  decode accepts this cycle.
- out_pc  output  n  PC to decode.
- out_inst  output  IW  instruction to decode.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on the rising clk edge.
- Priority: rst > flush > handshake.
- Reset values: out_valid=0, in_ready=1, out_pc=0, out_inst=0, occupancy=0, skid entry invalid, state EMPTY.
- Accept occurs when in_valid&in_ready. Consume occurs when out_valid&out_ready.
- All outputs are registered, except as stated under Optional Feature.
- Latency: accept at edge k → out_valid=1 after edge k. Throughput: 1 per cycle when out_ready is held high.
- in_valid while in_ready=0 is ignored. Fetch must hold its data; this block does not check that.
- State EMPTY (occupancy 0, out_valid 0, in_ready 1):
  - accept → main<=in, go BUSY.
  - otherwise stay.
- State BUSY (occupancy 1, out_valid 1, in_ready 1):
  - accept & consume → main<=in, stay BUSY.
  - accept & !consume → skid<=in, go FULL, in_ready<=0.
  - !accept & consume → go EMPTY.
  - neither → hold.
- State FULL (occupancy 2, out_valid 1, in_ready 0):
  - consume → main<=skid, go BUSY, in_ready<=1.
  - otherwise hold both entries.
- Ordering: strictly FIFO. The skid entry is never presented before main.
- flush=1 at an edge (any state) → go EMPTY, out_valid<=0, in_ready<=1, occupancy<=0.
  - An entry accepted in the same cycle is discarded.
  - A consume in the same cycle still counts from decode's side; the block simply drops its copies.
- out_pc/out_inst hold their last value while out_valid=0. They are not cleared by flush.
- rst asserted mid-transfer: all entries are dropped and the reset values apply after that edge. Handshakes during rst are ignored.
- occupancy always equals out_valid + skid_valid.

Optional Feature:
- Macro: IF_ID_NOP_BUBBLE_EN.
- Defined:
  - out_inst = NOP_WORD and out_pc = 0 whenever out_valid=0. This is a combinational select on the registered outputs.
  - Reset and flush therefore present a canonical bubble.
- Undefined:
  - out_pc/out_inst show the registered main entry regardless of out_valid, i.e. stale values hold.
  - Handshake timing is identical in both builds.

Test Plan:
- Reset and bubble:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: out_valid=0, in_ready=1, occupancy=0, out_inst=0.
  - With IF_ID_NOP_BUBBLE_EN, out_inst=32'h00000013.
- Streaming:
  - Stimulus: out_ready=1; present PCs 0x0,0x4,0x8 with insts 0xA,0xB,0xC on consecutive cycles.
  - Required: each appears on out_pc/out_inst exactly one cycle after acceptance, back-to-back; occupancy stays 1.
- Back-pressure and skid:
  - Stimulus: BUSY holding 0x10/0x111; out_ready=0; accept 0x14/0x222.
  - Required: occupancy=2, in_ready=0 next cycle, out_pc stays 0x10.
  - Then out_ready=1 for 2 cycles → 0x10 then 0x14 delivered in order; in_ready returns to 1 after the first consume.
- Flush in FULL:
  - Stimulus: state FULL (0x20, 0x24); assert flush with in_valid=1, in_pc=0x28.
  - Required: next cycle out_valid=0, occupancy=0, in_ready=1; 0x28 is never delivered.
- Reset beats flush:
  - Stimulus: rst=1 and flush=1 together while BUSY with out_ready=0.
  - Required: reset values apply; the next accept of 0x40 appears one cycle later with occupancy=1.
- Random soak:
  - Stimulus: 10k cycles of random in_valid/out_ready/flush at 5%.
  - Required: the scoreboard sees no loss, duplication or reordering between flushes; occupancy always ≤2.

Source files
------------

// File: rtl/if_id_skid_register.sv
// ============================================================================
// if_id_skid_register
// ----------------------------------------------------------------------------
// Registered IF->ID pipeline boundary. Takes the fetch stage's selected PC and
// instruction and hands them to decode over a valid/ready handshake. A
// 2-entry skid buffer (main + skid) lets in_ready come straight from a flop.
// A flush discards every held entry plus any entry accepted in the same cycle.
//
// Optional feature macro: IF_ID_NOP_BUBBLE_EN
//   defined   : while out_valid=0, out_pc reads 0 and out_inst reads NOP_WORD
//               (combinational select after the output registers).
//   undefined : out_pc/out_inst always show the registered main entry, so
//               stale values remain visible while out_valid=0.
//   Handshake timing is the same in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (wins over flush)
//   in_valid   in   fetch presents in_pc/in_inst
//   in_ready   out  stage can accept (registered)
//   in_pc      in   fetched PC [n-1:0]
//   in_inst    in   fetched instruction [IW-1:0]
//   flush      in   discard all held and incoming entries
//   out_valid  out  out_pc/out_inst valid for decode
//   out_ready  in   decode accepts this cycle
//   out_pc     out  PC to decode [n-1:0]
//   out_inst   out  instruction to decode [IW-1:0]
//   occupancy  out  entries held: 0, 1 or 2
// ============================================================================
module if_id_skid_register #(
    parameter int              n        = 32,
    parameter int              IW       = 32,
    parameter logic [IW-1:0]   NOP_WORD = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n-1:0]   in_pc,
    input  logic [IW-1:0]  in_inst,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n-1:0]   out_pc,
    output logic [IW-1:0]  out_inst,
    output logic [1:0]     occupancy
);

`ifdef IF_ID_NOP_BUBBLE_EN
    localparam bit BUBBLE_EN = 1'b1;
`else
    localparam bit BUBBLE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_q,      state_d;
    logic [n-1:0]   main_pc_q,    main_pc_d;
    logic [IW-1:0]  main_inst_q,  main_inst_d;
    logic [n-1:0]   skid_pc_q,    skid_pc_d;
    logic [IW-1:0]  skid_inst_q,  skid_inst_d;
    logic           in_ready_q,   in_ready_d;
    logic           out_valid_q,  out_valid_d;
    logic [1:0]     occupancy_q,  occupancy_d;

    logic accept;
    logic consume;

    // in_ready/out_valid are the registered flags, so the handshakes are
    // evaluated purely from flop outputs and the incoming valid/ready.
    assign accept  = in_valid  & in_ready_q;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        if (flush) begin
            // Data registers keep their contents so out_pc/out_inst hold
            // their last value; only the bookkeeping returns to EMPTY.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                        state_d     = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                    end else if (accept) begin
                        skid_pc_d   = in_pc;
                        skid_inst_d = in_inst;
                        state_d     = FULL;
                    end else if (consume) begin
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (consume) begin
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                        state_d     = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Flags are registered copies of what the next state implies.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        unique case (state_d)
            BUSY:    occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occupancy_q;

    // Bubble substitution sits after the registers so the handshake path is
    // identical whether or not the feature is built in.
    assign out_pc   = (BUBBLE_EN && !out_valid_q) ? '0       : main_pc_q;
    assign out_inst = (BUBBLE_EN && !out_valid_q) ? NOP_WORD : main_inst_q;

endmodule
